lcd_write_arbiter: RTL and testbench
====================================

# lcd_write_arbiter

Shares a single framebuffer write port between the two Game Boy pixel producers of the dual-LCD display. Each producer streams 15-bit pixels at its own irregular rate; the block buffers each stream in a small FIFO, computes the side-by-side framebuffer address (source 1 at x 0..159, source 2 at x 160..319, 320×144), and grants the write port round-robin. It sits between the two PPU pixel outputs and the 320×144 framebuffer RAM's write port. The scan-out side reads that RAM independently.

## Interface
Parameters:
- FIFO_DEPTH, 4, entries per source FIFO (power of two, ≥2)
- GB_W, 160, pixels per source line
- GB_H, 144, lines per source frame

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- clkena1  in  1  source 1 pixel valid, one pixel per asserted cycle
- data1  in  15  source 1 pixel, BGR555 or 2-bit DMG index in [1:0]
- mode1  in  2  source 1 PPU mode; 2'b01 = vblank
- on1  in  1  source 1 LCD enable
- clkena2, data2, mode2, on2  in  1/15/2/1  same for source 2
- wr_en  out  1  framebuffer write strobe
- wr_addr  out  16  framebuffer word address, y*320 + x
- wr_data  out  15  framebuffer write data
- ovf1, ovf2  out  1  sticky: pixel dropped due to full FIFO; cleared only by reset
- frame_done1, frame_done2  out  1  one-cycle pulse when the source's last pixel (x=159, y=143) is accepted

## Operation
- Per source position counters x (0..GB_W-1), y (0..GB_H-1):
  - Cleared when on=0 or mode=01.
  - Otherwise advance on every clkena, including dropped pixels, so later pixels keep correct placement.
  - x wraps 159→0 with y+1.
  - After (159,143), the frame is complete. Further clkena until the clear condition are discarded silently: no write, no ovf.
- Push: on clkena with frame not complete, compute addr = (y<<8)+(y<<6)+x+(src2 ? GB_W : 0), 16-bit unsigned.
  - If FIFO not full, push {addr, data}.
  - If full, drop the pixel and set ovf.
  - Full is evaluated before the same-cycle pop; no bypass.
- on=0 additionally flushes that source's FIFO. Pending entries are discarded.
- mode=01 does not flush. Queued pixels of the finishing frame still drain.
- Arbiter states, encoded as a last-grant pointer:
  - LAST1 (reset value is LAST2, so source 1 wins first).
  - With both FIFOs non-empty, grant the source not last granted.
  - With one non-empty, grant it and do not change the pointer's fairness sense: pointer = granted source.
  - With none, idle.
- At most one pop per cycle. The popped entry is registered onto wr_addr/wr_data with wr_en=1 for exactly one cycle.
- With wr_en=0, wr_addr and wr_data hold their last value.

## Timing
- Reset: wr_en=0, wr_addr=0, wr_data=0, ovf1=ovf2=0, frame_done1=frame_done2=0, counters 0, FIFOs empty, pointer=LAST2.
- Latency, uncontended with empty FIFO:
  - clkena sampled at edge N → entry in FIFO after N.
  - Popped at edge N+1 → wr_en high from N+1 to N+2.
  - Total 2 cycles.
- Throughput: one write per clock aggregate. Two sources each pushing every cycle overflow after FIFO fills; each sustained source gets exactly 1/2.
- frame_done pulses in the cycle after edge sampling the accepting clkena, coincident with position update.
- Simultaneous clkena and clear condition: clear wins; the pixel is not pushed.
- Simultaneous push and pop on the same FIFO: both occur; count unchanged.
- reset mid-frame: all state returns to reset values next cycle. An in-flight wr_en is cancelled.

## Structure
- Shared package lcd_pkg:
  - constants LCD_W=320, GB_W=160, GB_H=144, FB_AW=16.
  - typedef fb_entry_t {addr[15:0], data[14:0]}.
  - typedef grant_t {LAST1, LAST2}.
- Sub-module lcd_wr_fifo, instantiated twice:
  - Synchronous FIFO of fb_entry_t with push, pop, flush, full, empty.
  - Show-ahead read data.
- Top contains the counters, address arithmetic, arbiter and output register.

## Test plan
- Single pixel: reset, then clkena1=1 one cycle with data1=15'h7FFF, on1=1, mode1=11 → wr_en high exactly one cycle 2 clocks later, wr_addr=0, wr_data=7FFF.
- Address mapping: source 2 delivers 161 pixels → 161st write has wr_addr=320+0+160=480. Source 1 full frame → last addr=143*320+159=45919, frame_done1 pulses once.
- Contention: both sources push every cycle for 8 cycles → writes alternate 1,2,1,2…, starting with source 1. With FIFO_DEPTH=4, ovf1 and ovf2 both set and stay set. Accepted pixel addresses remain correctly spaced.
- Vblank mid-queue: 3 pixels queued on source 1, mode1→01 → all 3 still written. Next pixel after vblank has addr 0.
- LCD off: 3 pixels queued on source 2, on2→0 → no further source-2 writes. Counters return to 0.
- Reset during traffic: reset asserted while wr_en=1 → next cycle wr_en=0, ovf cleared, no writes until new clkena.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the dual-LCD framebuffer write path.
package lcd_pkg;
  localparam int unsigned LCD_W = 320;
  localparam int unsigned GB_W  = 160;
  localparam int unsigned GB_H  = 144;
  localparam int unsigned FB_AW = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [14:0] data;
  } fb_entry_t;

  typedef enum logic {LAST1, LAST2} grant_t;
endpackage

// File: rtl/lcd_wr_fifo.sv
// Small synchronous show-ahead FIFO of framebuffer entries with flush.
module lcd_wr_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  fb_entry_t wdata,
  output fb_entry_t rdata,
  output logic      full,
  output logic      empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  fb_entry_t      mem [DEPTH];
  logic [AW-1:0]  wp, rp;
  logic [AW:0]    cnt;
  logic           do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign rdata   = mem[rp];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= wdata;
  end
endmodule

// File: rtl/lcd_write_arbiter.sv
// Merges two Game Boy pixel streams into one side-by-side 320x144 framebuffer
// write port: per-source position counters and FIFOs, round-robin grant.
module lcd_write_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GB_W       = 160,
  parameter int unsigned GB_H       = 144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkena1,
  input  logic [14:0] data1,
  input  logic [1:0]  mode1,
  input  logic        on1,
  input  logic        clkena2,
  input  logic [14:0] data2,
  input  logic [1:0]  mode2,
  input  logic        on2,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [14:0] wr_data,
  output logic        ovf1,
  output logic        ovf2,
  output logic        frame_done1,
  output logic        frame_done2
);
  import lcd_pkg::*;

  localparam int unsigned XW = $clog2(GB_W);
  localparam int unsigned YW = $clog2(GB_H);

  logic [1:0]  ena, on, clr, acc, push, pop, full, empty, avail, ovf_v, fd_v;
  logic [14:0] din [2];
  fb_entry_t   wdat [2], rdat [2];
  grant_t      ptr, ptr_nxt;

  assign ena     = {clkena2, clkena1};
  assign on      = {on2, on1};
  assign clr     = {~on2 | (mode2 == 2'b01), ~on1 | (mode1 == 2'b01)};
  assign din[0]  = data1;
  assign din[1]  = data2;

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic             done, last, ovf_q, fd_q;
    logic [FB_AW-1:0] addr;

    assign last    = (x == XW'(GB_W - 1)) && (y == YW'(GB_H - 1));
    // Dropped pixels still advance the position so later pixels land correctly.
    assign acc[s]  = ena[s] & ~clr[s] & ~done;
    assign push[s] = acc[s] & ~full[s];
    assign addr    = (FB_AW'(y) << 8) + (FB_AW'(y) << 6) + FB_AW'(x)
                   + FB_AW'(s * GB_W);
    assign wdat[s] = {addr, din[s]};
    assign ovf_v[s] = ovf_q;
    assign fd_v[s]  = fd_q;

    always_ff @(posedge clk) begin
      if (reset || clr[s]) begin
        x    <= '0;
        y    <= '0;
        done <= 1'b0;
      end else if (acc[s]) begin
        if (x == XW'(GB_W - 1)) begin
          x <= '0;
          if (y == YW'(GB_H - 1)) begin
            y    <= '0;
            done <= 1'b1;
          end else begin
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        ovf_q <= 1'b0;
        fd_q  <= 1'b0;
      end else begin
        fd_q <= acc[s] & last;
        if (acc[s] && full[s]) ovf_q <= 1'b1;
      end
    end

    lcd_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (~on[s]),
      .push  (push[s]),
      .pop   (pop[s]),
      .wdata (wdat[s]),
      .rdata (rdat[s]),
      .full  (full[s]),
      .empty (empty[s])
    );
  end

  // A source being switched off is flushing, so it must not be granted.
  assign avail = ~empty & on;

  always_comb begin
    pop     = '0;
    ptr_nxt = ptr;
    if (avail == 2'b11) begin
      if (ptr == LAST1) begin
        pop     = 2'b10;
        ptr_nxt = LAST2;
      end else begin
        pop     = 2'b01;
        ptr_nxt = LAST1;
      end
    end else if (avail[0]) begin
      pop     = 2'b01;
      ptr_nxt = LAST1;
    end else if (avail[1]) begin
      pop     = 2'b10;
      ptr_nxt = LAST2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= LAST2;
    else       ptr <= ptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= |pop;
      if (pop[0])      {wr_addr, wr_data} <= rdat[0];
      else if (pop[1]) {wr_addr, wr_data} <= rdat[1];
    end
  end

  assign ovf1        = ovf_v[0];
  assign ovf2        = ovf_v[1];
  assign frame_done1 = fd_v[0];
  assign frame_done2 = fd_v[1];
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Scoreboard bench for lcd_write_arbiter: a queue-based model predicts writes,
// overflow and frame-done; a negedge monitor compares.
module tb_lcd_write_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        e1 = 0, e2 = 0, o1 = 1, o2 = 1;
  logic [14:0] d1 = '0, d2 = '0;
  logic [1:0]  m1 = 2'b11, m2 = 2'b11;
  logic        wr_en, ovf1, ovf2, frame_done1, frame_done2;
  logic [15:0] wr_addr;
  logic [14:0] wr_data;

  lcd_write_arbiter #(.FIFO_DEPTH(DEPTH), .GB_W(160), .GB_H(144)) dut (
    .clk(clk), .reset(reset),
    .clkena1(e1), .data1(d1), .mode1(m1), .on1(o1),
    .clkena2(e2), .data2(d2), .mode2(m2), .on2(o2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ovf1(ovf1), .ovf2(ovf2),
    .frame_done1(frame_done1), .frame_done2(frame_done2)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: pixels placed by counting, queues as FIFOs, last-grant index.
  logic [30:0] mq [2][$];
  logic [30:0] sb [$];
  int mx [2], my [2];
  bit mdone [2], eovf [2], efd [2];
  int mlast = 1;

  always @(posedge clk) begin
    bit    ena [2], onv [2];
    int    mode [2], sz [2];
    logic [14:0] dv [2];
    bit    av [2];
    int    g;
    ena = '{e1, e2}; onv = '{o1, o2}; mode = '{int'(m1), int'(m2)}; dv = '{d1, d2};
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        mq[s].delete(); mx[s] = 0; my[s] = 0; mdone[s] = 0; eovf[s] = 0; efd[s] = 0;
      end
      mlast = 1;
    end else begin
      for (int s = 0; s < 2; s++) begin
        sz[s] = mq[s].size();
        av[s] = (sz[s] > 0) && onv[s];
      end
      g = -1;
      if (av[0] && av[1]) g = (mlast == 0) ? 1 : 0;
      else if (av[0])     g = 0;
      else if (av[1])     g = 1;
      if (g >= 0) begin
        sb.push_back(mq[g].pop_front());
        mlast = g;
      end
      for (int s = 0; s < 2; s++) begin
        efd[s] = 0;
        if (!onv[s]) mq[s].delete();
        if (!onv[s] || mode[s] == 1) begin
          mx[s] = 0; my[s] = 0; mdone[s] = 0;
        end else if (ena[s] && !mdone[s]) begin
          if (sz[s] >= DEPTH) eovf[s] = 1;
          else mq[s].push_back({16'(my[s] * 320 + mx[s] + s * 160), dv[s]});
          if (mx[s] == 159 && my[s] == 143) begin
            efd[s] = 1; mdone[s] = 1; mx[s] = 0; my[s] = 0;
          end else if (mx[s] == 159) begin
            mx[s] = 0; my[s]++;
          end else mx[s]++;
        end
      end
    end
  end

  logic [15:0] last_addr = '0;
  int fd1_cnt = 0;
  always @(negedge clk) begin
    logic [30:0] e;
    if (wr_en) begin
      if (sb.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wr_addr", wr_addr, e[30:15]);
        chk("wr_data", wr_data, e[14:0]);
      end
      last_addr = wr_addr;
    end else if (sb.size() != 0) begin
      chk("missing_write", sb.size(), 0);
      sb.delete();
    end
    chk("ovf1", ovf1, eovf[0]);
    chk("ovf2", ovf2, eovf[1]);
    chk("frame_done1", frame_done1, efd[0]);
    chk("frame_done2", frame_done2, efd[1]);
    if (frame_done1) fd1_cnt++;
  end

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(bit a1, bit a2);
    e1 = a1; d1 = 15'($urandom);
    e2 = a2; d2 = 15'($urandom);
    step();
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);

    // Single pixel, then explicit two-cycle latency.
    e1 = 1; d1 = 15'h7FFF; step(); e1 = 0;
    chk("lat_cycle1_idle", wr_en, 0);
    step();
    chk("lat_cycle2_wr_en", wr_en, 1);
    chk("lat_addr", wr_addr, 0);
    chk("lat_data", wr_data, 15'h7FFF);
    step(); chk("lat_one_cycle", wr_en, 0);
    step(2);

    // Source 2: 161 pixels, 161st lands on line 1 at x=160.
    repeat (161) drive(0, 1);
    drive(0, 0); step(4);
    chk("src2_161_addr", last_addr, 480);

    // Source 1 full frame plus discarded extras.
    o1 = 0; step(); o1 = 1;
    fd1_cnt = 0;
    repeat (160 * 144) drive(1, 0);
    drive(0, 0); step(4);
    chk("frame_last_addr", last_addr, 45919);
    chk("frame_done1_count", fd1_cnt, 1);
    repeat (3) drive(1, 0);
    drive(0, 0); step(4);

    // Contention from fresh positions.
    m1 = 2'b01; m2 = 2'b01; step(); m1 = 2'b11; m2 = 2'b11;
    repeat (8) drive(1, 1);
    drive(0, 0); step(10);
    chk("contention_ovf1", ovf1, 1);
    chk("contention_ovf2", ovf2, 1);

    // Vblank while source 1 has queued pixels; clear wins over clkena.
    m1 = 2'b01; m2 = 2'b01; step(); m1 = 2'b11; m2 = 2'b11;
    repeat (3) drive(1, 1);
    m1 = 2'b01; drive(1, 0);
    m1 = 2'b11; drive(0, 0); step(8);
    drive(1, 0); drive(0, 0); step(4);
    chk("after_vblank_addr", last_addr, 0);

    // LCD off flushes source 2.
    repeat (3) drive(1, 1);
    o2 = 0; drive(0, 0); drive(0, 0); step(6);
    o2 = 1; step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      m1 = ($urandom_range(0, 99) < 4) ? 2'b01 : 2'($urandom_range(2, 3));
      m2 = ($urandom_range(0, 99) < 4) ? 2'b01 : 2'($urandom_range(2, 3));
      o1 = ($urandom_range(0, 99) < 97);
      o2 = ($urandom_range(0, 99) < 97);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    m1 = 2'b11; m2 = 2'b11; o1 = 1; o2 = 1;
    drive(0, 0); step(10);

    // Reset while a write is on the port.
    e1 = 1; e2 = 1;
    for (int i = 0; i < 20 && !wr_en; i++) drive(1, 1);
    chk("reset_test_wr_seen", wr_en, 1);
    e1 = 0; e2 = 0; reset = 1; step(); reset = 0;
    chk("reset_cancel_wr_en", wr_en, 0);
    step(5);

    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
